// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Steps through the microcode of one opcode at a time. An opcode accepted in
// FETCH selects a ROM page ({op_reg, upc}). EXEC then walks that page one word
// per non-stalled cycle, registering each control word onto ctrl. Sequencing
// ends at a word marked uend, or with a sticky error if the page runs out
// without one. The HALT opcode parks the block until reset.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   instr_valid  in   an opcode is offered
//   instr_op     in   offered opcode [OP_W]
//   instr_ready  out  sequencer accepts an opcode (FETCH)
//   stall        in   freeze micro-sequencing (EXEC only)
//   rom_addr     out  microcode ROM address {op_reg, upc} [OP_W+UPC_W]
//   rom_data     in   ROM word: bit CW = uend, bits CW-1:0 = control word
//   ctrl         out  registered control word [CW]
//   ctrl_valid   out  ctrl carries a freshly sequenced word this cycle
//   pc_inc       out  one-cycle pulse: instruction complete
//   halted       out  sequencer is in HALT
//   err          out  sticky micro-PC overflow flag
// -----------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int              OP_W    = 4,
  parameter int              UPC_W   = 5,
  parameter int              CW      = 11,
  parameter logic [OP_W-1:0] HALT_OP = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  input  logic [OP_W-1:0]       instr_op,
  output logic                  instr_ready,
  input  logic                  stall,
  output logic [OP_W+UPC_W-1:0] rom_addr,
  input  logic [CW:0]           rom_data,
  output logic [CW-1:0]         ctrl,
  output logic                  ctrl_valid,
  output logic                  pc_inc,
  output logic                  halted,
  output logic                  err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [UPC_W-1:0] UPC_MAX = '1;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [CW-1:0]    ctrl_q, ctrl_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic             pc_inc_q, pc_inc_d;
  logic             err_q, err_d;

  logic uend;
  assign uend = rom_data[CW];

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path in always_comb infers a latch.
    state_d      = state_q;
    op_d         = op_q;
    upc_d        = upc_q;
    ctrl_d       = ctrl_q;
    err_d        = err_q;
    ctrl_valid_d = 1'b0;
    pc_inc_d     = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          op_d    = instr_op;
          upc_d   = '0;
          state_d = (instr_op == HALT_OP) ? HALT : EXEC;
        end
      end

      EXEC: begin
        if (!stall) begin
          ctrl_d       = rom_data[CW-1:0];
          ctrl_valid_d = 1'b1;
          if (uend) begin
            // upc is left on the last word; FETCH reloads it anyway.
            state_d  = FETCH;
            pc_inc_d = 1'b1;
          end else if (upc_q == UPC_MAX) begin
            // Page exhausted with no uend: flag it and give up on the
            // instruction rather than wrapping into word 0 again.
            err_d   = 1'b1;
            state_d = FETCH;
          end else begin
            upc_d = upc_q + UPC_W'(1);
          end
        end
      end

      HALT: begin
        // Parked until reset; everything holds.
      end

      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      op_q         <= '0;
      upc_q        <= '0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      upc_q        <= upc_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      pc_inc_q     <= pc_inc_d;
      err_q        <= err_d;
    end
  end

  assign rom_addr    = {op_q, upc_q};
  assign instr_ready = (state_q == FETCH);
  assign halted      = (state_q == HALT);
  assign ctrl        = ctrl_q;
  assign ctrl_valid  = ctrl_valid_q;
  assign pc_inc      = pc_inc_q;
  assign err         = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Drives directed opcodes into microcode_sequencer with a small combinational
// ROM model. Stimulus pushes the expected {ctrl, pc_inc} words into a queue;
// a monitor pops and compares each time ctrl_valid is seen. Level checks on
// ready/halted/err/rom_addr are made directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

  localparam int OP_W  = 4;
  localparam int UPC_W = 5;
  localparam int CW    = 11;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  instr_valid;
  logic [OP_W-1:0]       instr_op;
  logic                  instr_ready;
  logic                  stall;
  logic [OP_W+UPC_W-1:0] rom_addr;
  logic [CW:0]           rom_data;
  logic [CW-1:0]         ctrl;
  logic                  ctrl_valid;
  logic                  pc_inc;
  logic                  halted;
  logic                  err;

  microcode_sequencer #(
    .OP_W (OP_W),
    .UPC_W(UPC_W),
    .CW   (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_valid(instr_valid),
    .instr_op   (instr_op),
    .instr_ready(instr_ready),
    .stall      (stall),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .pc_inc     (pc_inc),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  // ROM contents:
  //   op 1: 0x1C0, 0x24F(uend)
  //   op 2: 0x400|upc, never uend (overflow case)
  //   op 3: 0x011, 0x022, 0x033(uend)
  function automatic logic [CW:0] rom_model(input logic [OP_W+UPC_W-1:0] a);
    logic [OP_W-1:0]  op;
    logic [UPC_W-1:0] u;
    op = a[OP_W+UPC_W-1:UPC_W];
    u  = a[UPC_W-1:0];
    case (op)
      4'h1: begin
        if (u == 5'd0)      rom_model = {1'b0, 11'h1C0};
        else if (u == 5'd1) rom_model = {1'b1, 11'h24F};
        else                rom_model = {1'b1, 11'h7FF};
      end
      4'h2:    rom_model = {1'b0, 11'h400 | {6'd0, u}};
      4'h3: begin
        if (u == 5'd0)      rom_model = {1'b0, 11'h011};
        else if (u == 5'd1) rom_model = {1'b0, 11'h022};
        else                rom_model = {1'b1, 11'h033};
      end
      default: rom_model = {1'b1, 11'h000};
    endcase
  endfunction

  always_comb rom_data = rom_model(rom_addr);

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic          pc_inc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [CW-1:0] c, input logic p);
    exp_t e;
    e.ctrl   = c;
    e.pc_inc = p;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented control word against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pc_inc) check("pc_inc_with_valid", {31'd0, ctrl_valid}, 32'd1);
      if (ctrl_valid) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_ctrl: got 0x%0h with no expected word at %0t", ctrl, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ctrl_word", {21'd0, ctrl}, {21'd0, e.ctrl});
          check("pc_inc", {31'd0, pc_inc}, {31'd0, e.pc_inc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    stall       = 1'b0;

    // Reset state
    #12;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_rom_addr", {23'd0, rom_addr}, 32'd0);
    check("rst_ctrl", {21'd0, ctrl}, 32'd0);
    check("rst_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
    check("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Two-word instruction, no stall
    instr_op = 4'h1; instr_valid = 1'b1;
    push(11'h1C0, 1'b0);
    push(11'h24F, 1'b1);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("op1_ready_low", {31'd0, instr_ready}, 32'd0);
    check("op1_rom_addr", {23'd0, rom_addr}, 32'h020);
    tick(); tick();
    @(negedge clk);
    check("op1_ready_after", {31'd0, instr_ready}, 32'd1);
    tick();
    @(negedge clk);
    check("op1_ctrl_hold", {21'd0, ctrl}, 32'h24F);
    check("op1_valid_low", {31'd0, ctrl_valid}, 32'd0);

    // Same instruction, stalled two cycles after the first word
    instr_op = 4'h1; instr_valid = 1'b1;
    push(11'h1C0, 1'b0);
    push(11'h24F, 1'b1);
    tick();
    instr_valid = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("stall_ctrl_hold", {21'd0, ctrl}, 32'h1C0);
      check("stall_valid_low", {31'd0, ctrl_valid}, 32'd0);
      check("stall_upc_hold", {23'd0, rom_addr}, 32'h021);
    end
    stall = 1'b0;
    tick();
    tick();

    // Back-to-back: opcode 1 then 3 with instr_valid held high
    instr_op = 4'h1; instr_valid = 1'b1;
    push(11'h1C0, 1'b0);
    push(11'h24F, 1'b1);
    push(11'h011, 1'b0);
    push(11'h022, 1'b0);
    push(11'h033, 1'b1);
    tick();
    instr_op = 4'h3;
    @(negedge clk);
    check("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
    tick(); tick();
    @(negedge clk);
    check("b2b_ready_at_pc_inc", {31'd0, instr_ready}, 32'd1);
    check("b2b_pc_inc", {31'd0, pc_inc}, 32'd1);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_rom_addr", {23'd0, rom_addr}, 32'h060);
    check("b2b_ready_low2", {31'd0, instr_ready}, 32'd0);
    tick(); tick(); tick(); tick();
    @(negedge clk);
    check("b2b_ready_end", {31'd0, instr_ready}, 32'd1);

    // Stall ignored in FETCH; reset during the second word of a 3-word op
    stall = 1'b1;
    instr_op = 4'h3; instr_valid = 1'b1;
    push(11'h011, 1'b0);
    push(11'h022, 1'b0);
    tick();
    instr_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("fetch_stall_ignored", {23'd0, rom_addr}, 32'h060);
    tick(); tick();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {21'd0, ctrl}, 32'd0);
    check("mid_rst_valid", {31'd0, ctrl_valid}, 32'd0);
    check("mid_rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    check("mid_rst_rom_addr", {23'd0, rom_addr}, 32'd0);
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("post_rst_valid", {31'd0, ctrl_valid}, 32'd0);

    // Micro-PC overflow: 32 words, no uend
    instr_op = 4'h2; instr_valid = 1'b1;
    for (int k = 0; k < 32; k++) push(11'h400 | 11'(k), 1'b0);
    tick();
    instr_valid = 1'b0;
    repeat (31) tick();
    @(negedge clk);
    check("ovf_err_before", {31'd0, err}, 32'd0);
    tick();
    @(negedge clk);
    check("ovf_err_set", {31'd0, err}, 32'd1);
    check("ovf_ready", {31'd0, instr_ready}, 32'd1);
    check("ovf_no_wrap", {23'd0, rom_addr}, 32'h05F);

    // err stays set over the next instruction
    instr_op = 4'h1; instr_valid = 1'b1;
    push(11'h1C0, 1'b0);
    push(11'h24F, 1'b1);
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    tick();

    // HALT opcode
    instr_op = 4'hF; instr_valid = 1'b1;
    tick();
    @(negedge clk);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_ready", {31'd0, instr_ready}, 32'd0);
    instr_op = 4'h1;
    repeat (5) tick();
    @(negedge clk);
    check("halt_stays", {31'd0, halted}, 32'd1);
    check("halt_ready_stays", {31'd0, instr_ready}, 32'd0);
    check("halt_valid_low", {31'd0, ctrl_valid}, 32'd0);
    check("halt_ctrl_hold", {21'd0, ctrl}, 32'h24F);
    instr_valid = 1'b0;

    // Only reset leaves HALT; it also clears err
    #1;
    reset_n = 1'b0;
    #1;
    check("final_rst_halted", {31'd0, halted}, 32'd0);
    check("final_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
